// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the vector store path.
//   order_e    : lane placement inside a memory beat
//   pk_state_e : packer state machine
//   beats()    : number of memory beats needed per vector
package vec_mem_pkg;

   typedef enum logic {
      ORDER_MSB_FIRST = 1'b0,
      ORDER_LSB_FIRST = 1'b1
   } order_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } pk_state_e;

   function automatic int unsigned beats(input int unsigned lanes,
                                         input int unsigned lane_w,
                                         input int unsigned beat_w);
      return (lanes * lane_w) / beat_w;
   endfunction

endpackage

// File: rtl/vector_beat_select.sv
// Combinational beat selector: picks the lanes and mask bits of one beat out of the
// captured vector and places them in slot order.
//   lanes    : captured vector, lane i at [i*LANE_W +: LANE_W]
//   mask     : captured per-lane write enables
//   beat_idx : beat being presented
//   order    : MSB_FIRST puts the lowest lane of the beat in the MS slot
//   data     : beat data
//   lane_en  : per-slot enables, same slot mapping as data
module vector_beat_select
   import vec_mem_pkg::*;
#(
   parameter int unsigned LANES  = 16,
   parameter int unsigned LANE_W = 8,
   parameter int unsigned BEAT_W = 32,
   parameter int unsigned BEATS  = 4,
   parameter int unsigned CNT_W  = 2
) (
   input  logic [LANES*LANE_W-1:0]  lanes,
   input  logic [LANES-1:0]         mask,
   input  logic [CNT_W-1:0]         beat_idx,
   input  order_e                   order,
   output logic [BEAT_W-1:0]        data,
   output logic [BEAT_W/LANE_W-1:0] lane_en
);

   localparam int unsigned LPB = BEAT_W / LANE_W;

   logic [BEAT_W-1:0] beat_lanes;
   logic [LPB-1:0]    beat_mask;

   always_comb begin
      beat_lanes = '0;
      beat_mask  = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_idx == CNT_W'(b)) begin
            beat_lanes = lanes[b*BEAT_W +: BEAT_W];
            beat_mask  = mask[b*LPB +: LPB];
         end
      end

      data    = '0;
      lane_en = '0;
      for (int s = 0; s < LPB; s++) begin
         if (order == ORDER_LSB_FIRST) begin
            data[s*LANE_W +: LANE_W] = beat_lanes[s*LANE_W +: LANE_W];
            lane_en[s]               = beat_mask[s];
         end else begin
            data[(LPB-1-s)*LANE_W +: LANE_W] = beat_lanes[s*LANE_W +: LANE_W];
            lane_en[LPB-1-s]                 = beat_mask[s];
         end
      end
   end

endmodule

// File: rtl/vector_store_packer.sv
// Vector store packer: accepts one masked vector per handshake and streams it to the
// data-memory write port as BEATS beats of BEAT_W bits, optionally skipping empty beats.
//   clk, reset                  : clock, asynchronous active-high reset
//   in_valid/in_ready           : vector handshake
//   in_lanes/in_mask            : lane data and per-lane write enables
//   in_addr/in_order            : byte address of beat 0, lane order within a beat
//   mem_valid/mem_ready         : beat handshake
//   mem_addr/mem_data           : beat byte address and data
//   mem_lane_en/mem_last        : per-slot enables, final issued beat of the vector
//   busy                        : a vector is being streamed
module vector_store_packer
   import vec_mem_pkg::*;
#(
   parameter int unsigned LANES      = 16,
   parameter int unsigned LANE_W     = 8,
   parameter int unsigned BEAT_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter bit          SKIP_EMPTY = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*LANE_W-1:0]  in_lanes,
   input  logic [LANES-1:0]         in_mask,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     in_order,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [BEAT_W-1:0]        mem_data,
   output logic [BEAT_W/LANE_W-1:0] mem_lane_en,
   output logic                     mem_last,
   output logic                     busy
);

   localparam int unsigned BEATS      = beats(LANES, LANE_W, BEAT_W);
   localparam int unsigned LPB        = BEAT_W / LANE_W;
   localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned BEAT_BYTES = BEAT_W / 8;

   if ((BEAT_W % LANE_W) != 0) begin : g_bad_lane_w
      $error("BEAT_W must be a multiple of LANE_W");
   end
   if ((BEAT_W % 8) != 0) begin : g_bad_beat_w
      $error("BEAT_W must be a multiple of 8");
   end
   if (((LANES * LANE_W) % BEAT_W) != 0) begin : g_bad_vec_w
      $error("LANES*LANE_W must be a multiple of BEAT_W");
   end

   pk_state_e                state_q;
   logic [LANES*LANE_W-1:0]  lanes_q;
   logic [LANES-1:0]         mask_q;
   logic [ADDR_W-1:0]        addr_q;
   order_e                   order_q;
   logic [BEATS-1:0]         any_q;
   logic [CNT_W-1:0]         cnt_q;

   logic [BEATS-1:0] in_any;
   logic [CNT_W-1:0] first_cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             has_next;
   logic             accept;

   // Descending scans so the lowest qualifying beat index wins.
   always_comb begin
      in_any = '0;
      for (int b = 0; b < BEATS; b++) begin
         in_any[b] = |in_mask[b*LPB +: LPB];
      end

      first_cnt = '0;
      for (int b = BEATS - 1; b >= 0; b--) begin
         if (!SKIP_EMPTY || in_any[b]) first_cnt = CNT_W'(b);
      end

      next_cnt = cnt_q;
      has_next = 1'b0;
      for (int b = BEATS - 1; b >= 0; b--) begin
         if ((b > int'(cnt_q)) && (!SKIP_EMPTY || any_q[b])) begin
            next_cnt = CNT_W'(b);
            has_next = 1'b1;
         end
      end
   end

   assign mem_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign mem_last  = (state_q == SEND) && !has_next;
   assign mem_addr  = addr_q + ADDR_W'(cnt_q) * ADDR_W'(BEAT_BYTES);
   // A new vector may enter on the same edge that the last beat leaves.
   assign in_ready  = !reset && ((state_q == IDLE) || (mem_ready && mem_last));
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         lanes_q <= '0;
         mask_q  <= '0;
         addr_q  <= '0;
         order_q <= ORDER_MSB_FIRST;
         any_q   <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         lanes_q <= in_lanes;
         mask_q  <= in_mask;
         addr_q  <= in_addr;
         order_q <= order_e'(in_order);
         any_q   <= in_any;
         cnt_q   <= first_cnt;
         // A fully masked vector has nothing to issue when empty beats are skipped.
         state_q <= (SKIP_EMPTY && (in_any == '0)) ? IDLE : SEND;
      end else if ((state_q == SEND) && mem_ready) begin
         if (mem_last) state_q <= IDLE;
         else          cnt_q   <= next_cnt;
      end
   end

   vector_beat_select #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS),
      .CNT_W  (CNT_W)
   ) u_beat_select (
      .lanes    (lanes_q),
      .mask     (mask_q),
      .beat_idx (cnt_q),
      .order    (order_q),
      .data     (mem_data),
      .lane_en  (mem_lane_en)
   );

endmodule
